// File: rtl/spectrum_framer_if.sv
// Signal bundle between the FFT output stream, the framer and the formant estimator.
//
// Handshake: there is no ready anywhere on this bundle. A bin beat is transferred on
// every rising clock edge where bin_valid is high; bin_re/bin_im/bin_last are only
// meaningful in that cycle. On the output side fft_data is meaningful only while
// fft_valid is high, and the consumer must accept every such beat; formant_busy is a
// level that only gates when a held frame may start replaying.
interface spectrum_framer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                        bin_valid;
  logic signed [IN_WIDTH-1:0]  bin_re;
  logic signed [IN_WIDTH-1:0]  bin_im;
  logic                        bin_last;
  logic                        formant_busy;
  logic                        fft_valid;
  logic [BIT_WIDTH-1:0]        fft_data;
  logic                        frame_dropped;
  logic [CNT_WIDTH-1:0]        drop_count;
  logic [1:0]                  state_dbg;

  // Driver side: produces bins and the busy level, observes the framer outputs.
  modport master (
    output bin_valid, bin_re, bin_im, bin_last, formant_busy,
    input  fft_valid, fft_data, frame_dropped, drop_count, state_dbg
  );

  // Framer side.
  modport slave (
    input  bin_valid, bin_re, bin_im, bin_last, formant_busy,
    output fft_valid, fft_data, frame_dropped, drop_count, state_dbg
  );
endinterface

// File: rtl/spectrum_framer.sv
// Captures the first I bin powers of one FFT frame and replays them as a
// gap-free I-cycle burst once the formant estimator is idle. Frames that arrive
// while a frame is held or replaying are discarded and counted.
module spectrum_framer #(
  parameter int IN_WIDTH  = 16,
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  spectrum_framer_if.slave   bus
);

  localparam int IDX_W  = $clog2(I + 1);
  localparam int ADDR_W = $clog2(I);
  localparam int PROD_W = 2 * IN_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(I);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(I - 1);
  localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(I - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  // Reset asserts immediately but is released only after two clean clock edges.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_pipe <= 2'b00;
    else           rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Bin index of the incoming beat: restarts after bin_last, saturates at I.
  logic [IDX_W-1:0] bin_idx;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bin_idx <= '0;
    end else if (bus.bin_valid) begin
      if (bus.bin_last)          bin_idx <= '0;
      else if (bin_idx != IDX_MAX) bin_idx <= bin_idx + 1'b1;
    end
  end

  // Stage 1: square both components (squares are never negative).
  logic signed [PROD_W-1:0] sq_re_c, sq_im_c;
  logic                     s1_valid, s1_last;
  logic [IDX_W-1:0]         s1_idx;
  logic [PROD_W-1:0]        s1_sq_re, s1_sq_im;

  assign sq_re_c = bus.bin_re * bus.bin_re;
  assign sq_im_c = bus.bin_im * bus.bin_im;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_sq_re <= '0;
      s1_sq_im <= '0;
    end else begin
      s1_valid <= bus.bin_valid;
      s1_last  <= bus.bin_last;
      s1_idx   <= bin_idx;
      s1_sq_re <= sq_re_c;
      s1_sq_im <= sq_im_c;
    end
  end

  // Stage 2 adder; the sum saturates only when its value does not fit BIT_WIDTH.
  logic [SUM_W-1:0]     sum_c;
  logic [BIT_WIDTH-1:0] pow_c;

  assign sum_c = {1'b0, s1_sq_re} + {1'b0, s1_sq_im};

  generate
    if (SUM_W > BIT_WIDTH) begin : g_sat
      assign pow_c = (|sum_c[SUM_W-1:BIT_WIDTH]) ? '1 : sum_c[BIT_WIDTH-1:0];
    end else begin : g_ext
      assign pow_c = BIT_WIDTH'(sum_c);
    end
  endgenerate

  logic                 w_valid, w_last;
  logic [IDX_W-1:0]     w_idx;
  logic [BIT_WIDTH-1:0] w_pow;

  // Stage 2 register: this is the pipeline output the FSM acts on.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
      w_idx   <= '0;
      w_pow   <= '0;
    end else begin
      w_valid <= s1_valid;
      w_last  <= s1_last;
      w_idx   <= s1_idx;
      w_pow   <= pow_c;
    end
  end

  state_t            state, state_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic              wr_en, rd_en, drop;
  logic              w_bin0;

  assign w_bin0 = w_valid && (w_idx == '0);

  // Next-state, buffer write/read enables and drop detection.
  always_comb begin
    state_n   = state;
    rd_addr_n = rd_addr;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (w_bin0) begin
          if (w_last) begin
            // A one-bin frame is as short as a frame can be.
            drop = 1'b1;
          end else begin
            wr_en   = 1'b1;
            state_n = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (w_valid) begin
          if (w_idx == IDX_LAST) begin
            wr_en   = 1'b1;
            state_n = S_HOLD;
          end else if (w_last) begin
            drop    = 1'b1;
            state_n = S_IDLE;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      S_HOLD: begin
        drop = w_bin0;
        if (!bus.formant_busy) begin
          state_n   = S_EMIT;
          rd_addr_n = '0;
        end
      end
      S_EMIT: begin
        // Still EMIT on the final read, so a bin 0 landing here is dropped too.
        drop  = w_bin0;
        rd_en = 1'b1;
        if (rd_addr == RD_LAST) state_n   = S_IDLE;
        else                    rd_addr_n = rd_addr + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and read-address registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_addr <= '0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
    end
  end

  assign bus.state_dbg = state;

  // Frame buffer write port; contents need no reset.
  logic [BIT_WIDTH-1:0] mem [I];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[w_idx[ADDR_W-1:0]] <= w_pow;
  end

  // Registered read port and output flags; outputs idle at zero.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bus.fft_valid     <= 1'b0;
      bus.fft_data      <= '0;
      bus.frame_dropped <= 1'b0;
      bus.drop_count    <= '0;
    end else begin
      bus.fft_valid     <= rd_en;
      bus.fft_data      <= rd_en ? mem[rd_addr] : '0;
      bus.frame_dropped <= drop;
      if (drop && (bus.drop_count != '1)) bus.drop_count <= bus.drop_count + 1'b1;
    end
  end

endmodule
